// File: rtl/irq_controller.sv
`timescale 1ns/1ps
// Purpose: vectored interrupt controller; latches edge/level sources and hands one
//          request at a time to the core (Irq/IrqAck/Eoi).
// Latency: source edge to Irq=1 is 2 cycles; Eoi to next Irq=1 is 2 cycles.
// Backpressure: one request outstanding. New requests stay latched in PENDING
//               until the core acks the current one and signals Eoi.
//
// Ports:
//   Clk, Rst     - clock; asynchronous active-low reset
//   i_ext        - interrupt sources, synchronous to Clk
//   Addr/WrEn/WData/RData - register port (0 ENABLE, 1 PENDING, 2 MODE, 3 STATUS);
//                  RData is combinational from Addr
//   Irq, IrqId   - request to the core and the selected / in-service source index
//   IrqAck, Eoi  - core accepts the request; core finished servicing it
module irq_controller #(
  parameter int N_SRC = 31
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N_SRC-1:0] i_ext,
  input  logic [1:0]       Addr,
  input  logic             WrEn,
  input  logic [31:0]      WData,
  output logic [31:0]      RData,
  output logic             Irq,
  output logic [4:0]       IrqId,
  input  logic             IrqAck,
  input  logic             Eoi
);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // Architectural state
  logic [N_SRC-1:0] en_src_q, en_src_d;
  logic             glb_en_q, glb_en_d;
  logic [N_SRC-1:0] mode_q,   mode_d;
  logic [N_SRC-1:0] pend_q,   pend_d;
  logic [N_SRC-1:0] prev_q;
  state_t           state_q,  state_d;
  logic [4:0]       irq_id_q, irq_id_d;

  // Decode and datapath helpers
  logic             wr_enable;
  logic             wr_pending;
  logic             wr_mode;
  logic [N_SRC-1:0] cand;
  logic             cand_any;
  logic [4:0]       sel_id;
  logic             ack_take;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] edge_set;
  logic             in_service;

  assign wr_enable  = WrEn && (Addr == ADDR_ENABLE);
  assign wr_pending = WrEn && (Addr == ADDR_PENDING);
  assign wr_mode    = WrEn && (Addr == ADDR_MODE);

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  always_comb begin
    en_src_d = en_src_q;
    glb_en_d = glb_en_q;
    mode_d   = mode_q;
    if (wr_enable) begin
      en_src_d = WData[N_SRC-1:0];
      glb_en_d = WData[31];
    end
    if (wr_mode) begin
      mode_d = WData[N_SRC-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Candidate selection: masking gates selection only, never latching.
  // ---------------------------------------------------------------------------
  assign cand     = pend_q & en_src_q & {N_SRC{glb_en_q}};
  assign cand_any = |cand;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel_id = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (cand[k]) begin
        sel_id = 5'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending bits
  // ---------------------------------------------------------------------------
  // An ack only counts while a request is actually being presented.
  assign ack_take = IrqAck && (state_q == ST_REQ);

  // Ack clears the bit of the id presented in the acking cycle.
  always_comb begin
    ack_clr = '0;
    for (int k = 0; k < N_SRC; k++) begin
      ack_clr[k] = ack_take && (irq_id_q == 5'(k));
    end
  end

  assign w1c_clr  = wr_pending ? WData[N_SRC-1:0] : '0;
  assign edge_set = i_ext & ~prev_q;

  // Edge sources: clear first, then OR in the set so a same-cycle edge survives.
  // Level sources simply mirror the registered input line.
  assign pend_d = (mode_q & i_ext)
                | (~mode_q & ((pend_q & ~(w1c_clr | ack_clr)) | edge_set));

  // ---------------------------------------------------------------------------
  // Request / service FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    Irq        = 1'b0;
    in_service = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          state_d  = ST_REQ;
          irq_id_d = sel_id;
        end
      end
      ST_REQ: begin
        Irq = 1'b1;
        // The core accepted what it saw this cycle, so the ack takes
        // precedence over a candidate set that just emptied.
        if (IrqAck) begin
          state_d = ST_SERVICE;
        end else if (!cand_any) begin
          state_d = ST_IDLE;
        end else begin
          // Re-select every cycle so a higher-priority arrival pre-empts.
          irq_id_d = sel_id;
        end
      end
      ST_SERVICE: begin
        in_service = 1'b1;
        if (Eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign IrqId = irq_id_q;

  // ---------------------------------------------------------------------------
  // Register read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    RData = '0;
    unique case (Addr)
      ADDR_ENABLE: begin
        RData[N_SRC-1:0] = en_src_q;
        RData[31]        = glb_en_q;
      end
      ADDR_PENDING: begin
        RData[N_SRC-1:0] = pend_q;
      end
      ADDR_MODE: begin
        RData[N_SRC-1:0] = mode_q;
      end
      ADDR_STATUS: begin
        RData[8]   = in_service;
        RData[7]   = Irq;
        RData[4:0] = irq_id_q;
      end
      default: begin
        RData = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      en_src_q <= '0;
      glb_en_q <= 1'b0;
      mode_q   <= '0;
      pend_q   <= '0;
      prev_q   <= '0;
      state_q  <= ST_IDLE;
      irq_id_q <= '0;
    end else begin
      en_src_q <= en_src_d;
      glb_en_q <= glb_en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      prev_q   <= i_ext;
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/1ps
// Bench for irq_controller: directed scenarios plus a randomized run
// checked against an abstract model of the controller.
module tb_irq_controller;

  logic        Clk;
  logic        Rst;
  logic [30:0] i_ext;
  logic [1:0]  Addr;
  logic        WrEn;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        Irq;
  logic [4:0]  IrqId;
  logic        IrqAck;
  logic        Eoi;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(.N_SRC(31)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .i_ext  (i_ext),
    .Addr   (Addr),
    .WrEn   (WrEn),
    .WData  (WData),
    .RData  (RData),
    .Irq    (Irq),
    .IrqId  (IrqId),
    .IrqAck (IrqAck),
    .Eoi    (Eoi)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  // requesting / servicing flags plus the id on offer describe the handshake.
  logic [30:0] m_en, m_mode, m_pend, m_prev;
  logic        m_glb;
  bit          m_req, m_svc;
  int          m_id;

  function automatic int lowest(input logic [30:0] v);
    for (int k = 0; k < 31; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return {m_glb, m_en};
      2'd1:    return {1'b0, m_pend};
      2'd2:    return {1'b0, m_mode};
      default: return {23'd0, m_svc, m_req, 2'b00, 5'(m_id)};
    endcase
  endfunction

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_glb = 1'b0;
    m_req = 0; m_svc = 0; m_id = 0;
  endtask

  // Advance one clock: the model consumes the inputs present before the edge.
  task automatic cycle();
    logic [30:0] ext_s, wd_s, np, cand;
    logic [31:0] wdat;
    logic [1:0]  a_s;
    bit          wr_s, ack, eoi;
    int          lo;
    ext_s = i_ext; wdat = WData; wd_s = WData[30:0]; a_s = Addr; wr_s = WrEn;
    cand  = m_glb ? (m_pend & m_en) : 31'd0;
    lo    = lowest(cand);
    ack   = IrqAck && m_req;
    eoi   = Eoi && m_svc;
    for (int k = 0; k < 31; k++) begin
      if (m_mode[k]) np[k] = ext_s[k];
      else begin
        np[k] = m_pend[k];
        if (wr_s && a_s == 2'd1 && wd_s[k]) np[k] = 1'b0;
        if (ack && m_id == k) np[k] = 1'b0;
        if (ext_s[k] && !m_prev[k]) np[k] = 1'b1;
      end
    end
    @(posedge Clk);
    #1;
    if (wr_s && a_s == 2'd0) begin m_en = wd_s; m_glb = wdat[31]; end
    if (wr_s && a_s == 2'd2) m_mode = wd_s;
    if (m_req) begin
      if (ack) begin m_req = 0; m_svc = 1; end
      else if (lo < 0) m_req = 0;
      else m_id = lo;
    end else if (m_svc) begin
      if (eoi) m_svc = 0;
    end else if (lo >= 0) begin
      m_req = 1; m_id = lo;
    end
    m_pend = np;
    m_prev = ext_s;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    Addr = a; WData = d; WrEn = 1'b1;
    cycle();
    WrEn = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = RData;
  endtask

  task automatic pulse_ack(); IrqAck = 1'b1; cycle(); IrqAck = 1'b0; endtask
  task automatic pulse_eoi(); Eoi = 1'b1; cycle(); Eoi = 1'b0; endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d;
    Rst = 1'b1;
    #1 Rst = 1'b0;
    #2;
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", Irq); end
    n_checks++; if (IrqId !== 5'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", IrqId); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
    end
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    cycle(); cycle();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    reg_write(2'd0, 32'h8000_0002);
    i_ext = 31'h2; cycle(); i_ext = '0;
    rd(2'd1, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL basic_pend: got %h want 2", d); end
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early: got %b want 0", Irq); end
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd1) begin n_fail++; $display("FAIL basic_req: got irq=%b id=%0d want 1/1", Irq, IrqId); end
    pulse_ack();
    rd(2'd1, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL basic_ack_pend: got %h want 0", d); end
    rd(2'd3, d);
    n_checks++; if (d !== 32'h101) begin n_fail++; $display("FAIL basic_ack_status: got %h want 101", d); end
    pulse_eoi();
    rd(2'd3, d);
    n_checks++; if (d !== 32'h001) begin n_fail++; $display("FAIL basic_eoi_status: got %h want 001", d); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    reg_write(2'd0, 32'h8000_00FF);
    i_ext = 31'h24; cycle(); i_ext = '0;
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd2) begin n_fail++; $display("FAIL prio_first: got irq=%b id=%0d want 1/2", Irq, IrqId); end
    pulse_ack();
    rd(2'd3, d);
    n_checks++; if (d !== 32'h102) begin n_fail++; $display("FAIL prio_svc_status: got %h want 102", d); end
    pulse_eoi();
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL prio_eoi_idle: got %b want 0", Irq); end
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd5) begin n_fail++; $display("FAIL prio_second: got irq=%b id=%0d want 1/5", Irq, IrqId); end
    i_ext = 31'h1; cycle(); i_ext = '0;
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd5) begin n_fail++; $display("FAIL preempt_before: got irq=%b id=%0d want 1/5", Irq, IrqId); end
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd0) begin n_fail++; $display("FAIL preempt_after: got irq=%b id=%0d want 1/0", Irq, IrqId); end
    pulse_ack();
    reg_write(2'd1, 32'h20);
    pulse_eoi();
    cycle();
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL prio_drained: got %b want 0", Irq); end
  endtask

  task automatic test_mask();
    logic [31:0] d;
    reg_write(2'd0, 32'h0000_0010);
    i_ext = 31'h10; cycle(); i_ext = '0;
    cycle();
    rd(2'd1, d);
    n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL mask_pend: got %h want 10", d); end
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b want 0", Irq); end
    reg_write(2'd0, 32'h8000_0010);
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL mask_en_early: got %b want 0", Irq); end
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd4) begin n_fail++; $display("FAIL mask_en_req: got irq=%b id=%0d want 1/4", Irq, IrqId); end
    reg_write(2'd1, 32'h10);
    rd(2'd1, d);
    n_checks++; if (d !== 32'h0 || Irq !== 1'b1) begin n_fail++; $display("FAIL mask_w1c: got pend=%h irq=%b want 0/1", d, Irq); end
    cycle();
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL mask_w1c_idle: got %b want 0", Irq); end
  endtask

  task automatic test_level();
    logic [31:0] d;
    reg_write(2'd2, 32'h8);
    reg_write(2'd0, 32'h8000_0008);
    i_ext = 31'h8; cycle(); cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd3) begin n_fail++; $display("FAIL level_req: got irq=%b id=%0d want 1/3", Irq, IrqId); end
    pulse_ack();
    rd(2'd1, d);
    n_checks++; if (d !== 32'h8) begin n_fail++; $display("FAIL level_ack_pend: got %h want 8", d); end
    pulse_eoi();
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL level_eoi_idle: got %b want 0", Irq); end
    cycle();
    n_checks++; if (Irq !== 1'b1 || IrqId !== 5'd3) begin n_fail++; $display("FAIL level_rereq: got irq=%b id=%0d want 1/3", Irq, IrqId); end
    pulse_ack();
    i_ext = '0; cycle();
    pulse_eoi();
    cycle();
    rd(2'd1, d);
    n_checks++; if (d !== 32'h0 || Irq !== 1'b0) begin n_fail++; $display("FAIL level_quiet: got pend=%h irq=%b want 0/0", d, Irq); end
    reg_write(2'd2, 32'h0);
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    reg_write(2'd0, 32'h0);
    i_ext = 31'h40; Addr = 2'd1; WData = 32'h40; WrEn = 1'b1;
    cycle();
    WrEn = 1'b0; i_ext = '0;
    rd(2'd1, d);
    n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL setclr_pend: got %h want 40", d); end
    pulse_ack();
    rd(2'd1, d);
    n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL stray_ack_pend: got %h want 40", d); end
    rd(2'd3, d);
    n_checks++; if (d[8:7] !== 2'b00) begin n_fail++; $display("FAIL stray_ack_state: got %b want 00", d[8:7]); end
    reg_write(2'd0, 32'h8000_0040);
    cycle();
    pulse_eoi();
    rd(2'd3, d);
    n_checks++; if (d !== 32'h86) begin n_fail++; $display("FAIL stray_eoi_status: got %h want 86", d); end
    reg_write(2'd1, 32'h40);
    cycle();
    n_checks++; if (Irq !== 1'b0) begin n_fail++; $display("FAIL setclr_idle: got %b want 0", Irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    reg_write(2'd2, 32'h5);
    i_ext = 31'h40; cycle(); i_ext = '0;
    cycle();
    pulse_ack();
    rd(2'd3, d);
    n_checks++; if (d !== 32'h106) begin n_fail++; $display("FAIL rmid_svc: got %h want 106", d); end
    #1 Rst = 1'b0;
    #1;
    n_checks++; if (Irq !== 1'b0 || IrqId !== 5'd0) begin n_fail++; $display("FAIL rmid_out: got irq=%b id=%0d want 0/0", Irq, IrqId); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rmid_reg%0d: got %h want 0", a, d); end
    end
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    i_ext = 31'h40; cycle(); i_ext = '0;
    cycle(); cycle();
    rd(2'd1, d);
    n_checks++; if (Irq !== 1'b0 || d !== 32'h40) begin n_fail++; $display("FAIL rmid_after: got irq=%b pend=%h want 0/40", Irq, d); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 600; it++) begin
      i_ext  = 31'($urandom & $urandom & $urandom);
      WrEn   = ($urandom_range(0, 9) < 2);
      Addr   = 2'($urandom);
      WData  = {($urandom_range(0, 3) != 0), 31'($urandom)};
      IrqAck = ($urandom_range(0, 2) == 0);
      Eoi    = ($urandom_range(0, 3) == 0);
      #1;
      n_checks++; if (Irq !== m_req) begin n_fail++; $display("FAIL rand_irq it%0d: got %b want %b", it, Irq, m_req); end
      n_checks++; if (IrqId !== 5'(m_id)) begin n_fail++; $display("FAIL rand_id it%0d: got %0d want %0d", it, IrqId, m_id); end
      n_checks++; if (RData !== exp_rdata(Addr)) begin n_fail++; $display("FAIL rand_rdata it%0d addr%0d: got %h want %h", it, Addr, RData, exp_rdata(Addr)); end
      cycle();
    end
    i_ext = '0; WrEn = 1'b0; IrqAck = 1'b0; Eoi = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_ext = '0; Addr = '0; WrEn = 1'b0; WData = '0; IrqAck = 1'b0; Eoi = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_level();
    test_set_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
